avalon_mem_agent: RTL

Avalon-MM read/write agent: a word-organised on-chip memory that answers the CPU's data or instruction host port. It completes the other end of the host protocol. Reads are pipelined with fixed latency, and writes use per-byte enables. Programmable wait-state injection drives `waitrequest` and `readdatavalid` timing, so the CPU's stall logic can be exercised. It is used in simulation benches and as the FPGA boot/data RAM.

---
 rtl/avalon_mem_agent_if.sv | 19 +
 rtl/avalon_mem_agent.sv | 81 ++++++++
 2 files changed

// File: rtl/avalon_mem_agent_if.sv
// avalon_mem_agent_if: Avalon-MM read/write bus between a host and a memory agent.
interface avalon_mem_agent_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        waitrequest;
  logic        readdatavalid;
  modport agent (
    input  address, read, write, byteenable, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );
  modport host (
    output address, read, write, byteenable, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avalon_mem_agent.sv
// avalon_mem_agent: word memory answering an Avalon-MM host, with wait-state injection and fixed read latency.
module avalon_mem_agent #(
  parameter int WORDS        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int WAIT_CYCLES  = 0,
  parameter     INIT_FILE    = ""
) (
  input  logic               clk,
  input  logic               rst,
  avalon_mem_agent_if.agent  port,
  output logic               error
);
  localparam int AW = $clog2(WORDS);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [WORDS];
  logic [READ_LATENCY-1:0] vld;
  logic [31:0] dat [READ_LATENCY];
  logic req, coll, acc, in_range, err_set;
  logic [AW-1:0] idx;
  logic unused_addr;
  assign unused_addr = ^port.address[1:0];
  assign idx = port.address[AW+1:2];
  assign in_range = ~|port.address[31:AW+2];
  assign req = port.read ^ port.write;
  assign coll = port.read & port.write;
  assign acc = req & ~port.waitrequest;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    port.waitrequest = 1'b0;
    err_set = 1'b0;
    if (coll) begin
      port.waitrequest = 1'b1;
      err_set = 1'b1;
      state_n = IDLE;
      cnt_n = '0;
    end else if (state == IDLE) begin
      if (req && WAIT_CYCLES > 0) begin
        port.waitrequest = 1'b1;
        cnt_n = 4'(WAIT_CYCLES - 1);
        state_n = HOLD;
      end
    end else if (!req) begin
      err_set = 1'b1;
      state_n = IDLE;
      cnt_n = '0;
    end else if (cnt != '0) begin
      port.waitrequest = 1'b1;
      cnt_n = cnt - 4'd1;
    end else begin
      state_n = IDLE;
    end
    if (!rst) port.waitrequest = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      error <= 1'b0;
      vld <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      error <= error | err_set | (acc & ~in_range);
      vld[0] <= acc & port.read;
      for (int i = 1; i < READ_LATENCY; i++) vld[i] <= vld[i-1];
    end
  end
  // Memory samples before the same-edge write, so a read sees only earlier writes.
  always_ff @(posedge clk) begin
    dat[0] <= in_range ? mem[idx] : '0;
    for (int i = 1; i < READ_LATENCY; i++) dat[i] <= dat[i-1];
    if (acc && port.write && in_range)
      for (int b = 0; b < 4; b++)
        if (port.byteenable[b]) mem[idx][8*b +: 8] <= port.host_to_agent[8*b +: 8];
  end
  assign port.readdatavalid = vld[READ_LATENCY-1];
  assign port.agent_to_host = vld[READ_LATENCY-1] ? dat[READ_LATENCY-1] : '0;
endmodule
